// File: rtl/iter_divider_if.sv
// Pipeline <-> iterative divider handshake: start/operands/cancel in, busy/done/results out.
interface iter_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             EXE_DivStart;
  logic             EXE_DivSigned;
  logic [WIDTH-1:0] EXE_ResultA;
  logic [WIDTH-1:0] EXE_ResultB;
  logic             Div_Cancel;
  logic             Div_Busy;
  logic             Div_Done;
  logic [WIDTH-1:0] Div_Quotient;
  logic [WIDTH-1:0] Div_Remainder;
  logic             Div_ByZero;

  modport master (
    output EXE_DivStart, EXE_DivSigned, EXE_ResultA, EXE_ResultB, Div_Cancel,
    input  Div_Busy, Div_Done, Div_Quotient, Div_Remainder, Div_ByZero
  );

  modport slave (
    input  EXE_DivStart, EXE_DivSigned, EXE_ResultA, EXE_ResultB, Div_Cancel,
    output Div_Busy, Div_Done, Div_Quotient, Div_Remainder, Div_ByZero
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider for MIPS DIV/DIVU (quotient -> LO, remainder -> HI).
// Define DIV_ZERO_FAST_EN to short-circuit a zero divisor straight to DONE with Div_ByZero.
module iter_divider #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           resetn,
  iter_divider_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
`ifdef DIV_ZERO_FAST_EN
  logic             zero_q, zero_d;
`endif

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH+1:0] trial;
  logic             ge;
  logic [WIDTH-1:0] step_rem, step_dvd;

  assign a_neg = bus.EXE_DivSigned & bus.EXE_ResultA[WIDTH-1];
  assign b_neg = bus.EXE_DivSigned & bus.EXE_ResultB[WIDTH-1];
  assign mag_a = a_neg ? -bus.EXE_ResultA : bus.EXE_ResultA;
  assign mag_b = b_neg ? -bus.EXE_ResultB : bus.EXE_ResultB;

  // Extra top bit keeps the shifted remainder (up to 2*|B|-1) exact; MSB of trial is the borrow.
  assign trial    = {1'b0, rem_q, dvd_q[WIDTH-1]} - {2'b00, dsr_q};
  assign ge       = ~trial[WIDTH+1];
  assign step_rem = ge ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign step_dvd = {dvd_q[WIDTH-2:0], ge};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    remo_d     = remo_q;
`ifdef DIV_ZERO_FAST_EN
    zero_d     = zero_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.EXE_DivStart && !bus.Div_Cancel) begin
          neg_quot_d = bus.EXE_DivSigned & (bus.EXE_ResultA[WIDTH-1] ^ bus.EXE_ResultB[WIDTH-1]);
          neg_rem_d  = a_neg;
          dvd_d      = mag_a;
          dsr_d      = mag_b;
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = StCalc;
`ifdef DIV_ZERO_FAST_EN
          zero_d     = 1'b0;
          if (bus.EXE_ResultB == '0) begin
            state_d = StDone;
            quot_d  = a_neg ? WIDTH'(1) : '1;
            remo_d  = bus.EXE_ResultA;
            zero_d  = 1'b1;
          end
`endif
        end
      end
      StCalc: begin
        if (bus.Div_Cancel) begin
          state_d = StIdle;
        end else begin
          rem_d = step_rem;
          dvd_d = step_dvd;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StDone;
            quot_d  = neg_quot_q ? -step_dvd : step_dvd;
            remo_d  = neg_rem_q ? -step_rem : step_rem;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      remo_q     <= '0;
`ifdef DIV_ZERO_FAST_EN
      zero_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      remo_q     <= remo_d;
`ifdef DIV_ZERO_FAST_EN
      zero_q     <= zero_d;
`endif
    end
  end

  assign bus.Div_Busy      = (state_q == StCalc);
  assign bus.Div_Done      = (state_q == StDone);
  assign bus.Div_Quotient  = quot_q;
  assign bus.Div_Remainder = remo_q;
`ifdef DIV_ZERO_FAST_EN
  assign bus.Div_ByZero    = bus.Div_Done & zero_q;
`else
  assign bus.Div_ByZero    = 1'b0;
`endif

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: directed vectors push expectations, a monitor checks on Done.
module tb_iter_divider;

  logic clk;
  logic resetn;

  iter_divider_if #(.WIDTH(32)) bus ();

  iter_divider #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        bz;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic prev_done    = 1'b0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLat  = 1;
  localparam int ZBusy = 0;
  localparam bit ZFlag = 1'b1;
`else
  localparam int ZLat  = 33;
  localparam int ZBusy = 32;
  localparam bit ZFlag = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && bus.Div_Done) begin
      chk("done_single_cycle", {31'b0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient", bus.Div_Quotient, e.q);
        chk("remainder", bus.Div_Remainder, e.r);
        chk("by_zero", {31'b0, bus.Div_ByZero}, {31'b0, e.bz});
      end
    end
    prev_done = resetn & bus.Div_Done;
  end

  task automatic wait_done(input int lat, input int nbusy);
    int  n    = 0;
    int  nb   = 0;
    bit  seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.Div_Busy) nb++;
      if (bus.Div_Done) seen = 1'b1;
    end
    chk("latency", n, lat);
    chk("busy_cycles", nb, nbusy);
  endtask

  task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.EXE_DivStart  = 1'b1;
    bus.EXE_DivSigned = sgn;
    bus.EXE_ResultA   = a;
    bus.EXE_ResultB   = b;
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic bz,
                         input int lat, input int nbusy);
    exp_t e;
    @(posedge clk); #1;
    drive(sgn, a, b);
    e.q = q; e.r = r; e.bz = bz;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.EXE_DivStart = 1'b0;
    wait_done(lat, nbusy);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    bus.EXE_DivStart  = 1'b0;
    bus.EXE_DivSigned = 1'b0;
    bus.EXE_ResultA   = '0;
    bus.EXE_ResultB   = '0;
    bus.Div_Cancel    = 1'b0;
    resetn            = 1'b0;
    #1;
    chk("rst_busy", {31'b0, bus.Div_Busy}, 32'd0);
    chk("rst_done", {31'b0, bus.Div_Done}, 32'd0);
    chk("rst_quot", bus.Div_Quotient, 32'd0);
    chk("rst_rem", bus.Div_Remainder, 32'd0);
    chk("rst_bz", {31'b0, bus.Div_ByZero}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;

    run_div(1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 33, 32);
    run_div(1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33, 32);
    run_div(1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,        1'b0, 33, 32);
    run_div(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE, 1'b0, 33, 32);
    run_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 33, 32);
    run_div(1'b0, 32'hFFFF_FFFF,  32'h10,       32'h0FFF_FFFF, 32'hF,         1'b0, 33, 32);
    run_div(1'b0, 32'd5,          32'd9,        32'd0,        32'd5,        1'b0, 33, 32);
    run_div(1'b1, 32'hFFFF_FFFB,  32'd0,        32'd1,        32'hFFFF_FFFB, ZFlag, ZLat, ZBusy);
    run_div(1'b0, 32'd7,          32'd0,        32'hFFFF_FFFF, 32'd7,        ZFlag, ZLat, ZBusy);

    // Start held high with operands changing mid-op: only the first sample counts.
    @(posedge clk); #1;
    drive(1'b0, 32'd1000, 32'd3);
    e.q = 32'd333; e.r = 32'd1; e.bz = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.EXE_ResultA = 32'd7;
    bus.EXE_ResultB = 32'd1;
    wait_done(33, 32);
    bus.EXE_DivStart = 1'b0;

    // Cancel mid-CALC: back to IDLE, no Done, outputs keep 333/1.
    @(posedge clk); #1;
    drive(1'b0, 32'd1000, 32'd3);
    @(posedge clk); #1;
    bus.EXE_DivStart = 1'b0;
    idle_cycles(9); #1;
    bus.Div_Cancel = 1'b1;
    @(posedge clk); #1;
    bus.Div_Cancel = 1'b0;
    chk("cancel_busy", {31'b0, bus.Div_Busy}, 32'd0);
    chk("cancel_quot_hold", bus.Div_Quotient, 32'd333);
    chk("cancel_rem_hold", bus.Div_Remainder, 32'd1);
    idle_cycles(40);
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 32);

    // Cancel wins over start in IDLE.
    @(posedge clk); #1;
    drive(1'b0, 32'd50, 32'd3);
    bus.Div_Cancel = 1'b1;
    @(posedge clk); #1;
    bus.EXE_DivStart = 1'b0;
    bus.Div_Cancel   = 1'b0;
    chk("cancel_wins_busy", {31'b0, bus.Div_Busy}, 32'd0);
    idle_cycles(40);

    // Async reset mid-CALC clears everything immediately and drops the op.
    @(posedge clk); #1;
    drive(1'b0, 32'd100, 32'd7);
    @(posedge clk); #1;
    bus.EXE_DivStart = 1'b0;
    idle_cycles(10); #3;
    resetn = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, bus.Div_Busy}, 32'd0);
    chk("midrst_quot", bus.Div_Quotient, 32'd0);
    chk("midrst_rem", bus.Div_Remainder, 32'd0);
    chk("midrst_done", {31'b0, bus.Div_Done}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle_cycles(40);
    run_div(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33, 32);

    idle_cycles(2);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
